// File: rtl/riscv_pkg.sv
// Shared fetch-stage definitions.
//   XLEN          : datapath width
//   NOP_INSTR     : addi x0,x0,0, presented to decode when nothing is queued
//   fetch_entry_t : one queued fetch result, {pc, instr}
package riscv_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry queue of fetch_entry_t between the fetch PC logic and decode.
//   clk, rst   : clock, synchronous active-high reset (empties the queue)
//   push       : write push_data at the tail (ignored when full without a pop)
//   push_data  : entry to write
//   pop        : drop the head entry (ignored when empty)
//   flush      : discard every entry; wins over push
//   full/empty : occupancy flags
//   head       : oldest entry, read from registered storage only
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output logic         full,
  output logic         empty,
  output fetch_entry_t head
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  fetch_entry_t  mem_q [DEPTH];

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop & ~empty;
    // A pop in the same cycle frees the slot, so push-while-full is allowed then.
    do_push  = push & (~full | do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // DEPTH is a power of two, so the pointers wrap naturally.
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: slots are only observed while counted as valid.
  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, addresses the instruction ROM, and queues
// {pc, instr} pairs for decode behind a valid/ready handshake.
//   clk, rst        : clock, synchronous active-high reset
//   imem_addr       : ROM byte address, equal to the PC register
//   imem_rdata      : ROM word for imem_addr, same cycle
//   redirect_valid  : redirect_pc is taken this cycle (flushes the queue)
//   redirect_pc     : redirect target; a misaligned target raises fetch_fault
//   out_valid/ready : handshake toward decode
//   out_instr/pc    : head entry (NOP / 0 when empty)
//   out_pc_plus4    : head PC + 4, 32-bit wrap
//   fetch_fault     : sticky misaligned-redirect flag; fetch stops until reset
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc_plus4,
  output logic        fetch_fault
);

  logic [31:0]  pc_q, pc_d;
  logic         fault_q, fault_d;
  logic         fifo_full, fifo_empty;
  fetch_entry_t fifo_head, push_entry;
  logic         deq, enq, redirect_take;

  assign imem_addr   = pc_q;
  assign fetch_fault = fault_q;

  // Outputs come only from queue state, never from out_ready or redirect inputs.
  assign out_valid    = ~fifo_empty;
  assign out_instr    = fifo_empty ? NOP_INSTR : fifo_head.instr;
  assign out_pc       = fifo_empty ? 32'h0 : fifo_head.pc;
  assign out_pc_plus4 = out_pc + 32'd4;

  assign push_entry = '{pc: pc_q, instr: imem_rdata};

  always_comb begin
    deq           = out_valid & out_ready;
    // Once faulted, redirects are ignored so the halted PC stays put.
    redirect_take = redirect_valid & ~fault_q;
    enq           = ~redirect_valid & ~fault_q & (~fifo_full | deq);
    pc_d          = pc_q;
    fault_d       = fault_q;
    if (redirect_take) begin
      if (redirect_pc[1:0] == 2'b00) begin
        pc_d = redirect_pc;
      end else begin
        fault_d = 1'b1;
      end
    end else if (enq) begin
      pc_d = pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      fault_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      fault_q <= fault_d;
    end
  end

  // A same-cycle dequeue still completes: decode already consumed that head.
  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (enq),
    .push_data(push_entry),
    .pop      (deq),
    .flush    (redirect_take),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head     (fifo_head)
  );

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  import riscv_pkg::*;

  localparam logic [31:0] RPC_A = 32'h0000_0000;
  localparam logic [31:0] RPC_B = 32'hFFFF_FFF8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, redirect_valid, out_ready;
  logic [31:0] redirect_pc;

  logic [31:0] a_addr, a_rdata, a_instr, a_pc, a_plus4;
  logic        a_valid, a_fault;
  logic [31:0] b_addr, b_rdata, b_instr, b_pc, b_plus4;
  logic        b_valid, b_fault;

  // ROM[i] = i, word index from addr[9:2]
  function automatic logic [31:0] rom(input logic [31:0] a);
    return {24'h0, a[9:2]};
  endfunction

  assign a_rdata = rom(a_addr);
  assign b_rdata = rom(b_addr);

  fetch_unit #(.RESET_PC(RPC_A), .DEPTH(2)) dut_a (
    .clk(clk), .rst(rst), .imem_addr(a_addr), .imem_rdata(a_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(a_valid), .out_ready(out_ready), .out_instr(a_instr),
    .out_pc(a_pc), .out_pc_plus4(a_plus4), .fetch_fault(a_fault)
  );

  fetch_unit #(.RESET_PC(RPC_B), .DEPTH(2)) dut_b (
    .clk(clk), .rst(rst), .imem_addr(b_addr), .imem_rdata(b_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(b_valid), .out_ready(out_ready), .out_instr(b_instr),
    .out_pc(b_pc), .out_pc_plus4(b_plus4), .fetch_fault(b_fault)
  );

  // Selected DUT under check
  bit          sel;
  logic [31:0] s_addr, s_instr, s_pc, s_plus4;
  logic        s_valid, s_fault;
  assign s_addr  = sel ? b_addr  : a_addr;
  assign s_instr = sel ? b_instr : a_instr;
  assign s_pc    = sel ? b_pc    : a_pc;
  assign s_plus4 = sel ? b_plus4 : a_plus4;
  assign s_valid = sel ? b_valid : a_valid;
  assign s_fault = sel ? b_fault : a_fault;

  // Reference model: queue of fetched entries, PC and fault flag
  fetch_entry_t mq[$];
  logic [31:0]  m_pc, m_reset_pc;
  bit           m_fault;
  localparam int MDEPTH = 2;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic hard_reset(input bit s, input logic [31:0] rp);
    sel = s; rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    @(posedge clk); @(negedge clk);
    m_reset_pc = rp; mq.delete(); m_pc = rp; m_fault = 1'b0;
  endtask

  // One clock: drive inputs, compare outputs with the model, advance the model.
  task automatic step(input bit r, input bit rv, input logic [31:0] rpc, input bit rdy);
    logic [31:0] e_pc, e_instr;
    bit deq, enq;
    fetch_entry_t e;
    rst = r; redirect_valid = rv; redirect_pc = rpc; out_ready = rdy;
    #1;
    e_pc    = (mq.size() != 0) ? mq[0].pc : 32'h0;
    e_instr = (mq.size() != 0) ? mq[0].instr : NOP_INSTR;
    chk("imem_addr", s_addr, m_pc);
    chk("out_valid", 32'(s_valid), 32'(mq.size() != 0));
    chk("out_pc", s_pc, e_pc);
    chk("out_instr", s_instr, e_instr);
    chk("out_pc_plus4", s_plus4, e_pc + 32'd4);
    chk("fetch_fault", 32'(s_fault), 32'(m_fault));
    deq = (mq.size() != 0) && rdy;
    enq = !rv && !m_fault && ((mq.size() < MDEPTH) || deq);
    if (r) begin
      mq.delete(); m_pc = m_reset_pc; m_fault = 1'b0;
    end else begin
      if (deq) void'(mq.pop_front());
      if (rv && !m_fault) begin
        mq.delete();
        if (rpc[1:0] == 2'b00) m_pc = rpc;
        else m_fault = 1'b1;
      end else if (enq) begin
        e.pc = m_pc; e.instr = rom(m_pc);
        mq.push_back(e);
        m_pc = m_pc + 32'd4;
      end
    end
    @(posedge clk); @(negedge clk);
  endtask

  initial begin
    logic [31:0] frozen, rpc;
    bit r, rv, rdy;

    hard_reset(1'b0, RPC_A);
    // Reset state
    chk("rst_valid", 32'(s_valid), 32'h0);
    chk("rst_instr", s_instr, 32'h0000_0013);
    chk("rst_pc", s_pc, 32'h0);
    chk("rst_plus4", s_plus4, 32'h4);
    chk("rst_fault", 32'(s_fault), 32'h0);
    chk("rst_addr", s_addr, RPC_A);

    // 1: streaming with out_ready=1
    step(0, 0, 0, 1);
    chk("t1_first_valid", 32'(s_valid), 32'h1);
    chk("t1_first_pc", s_pc, 32'h0);
    repeat (6) step(0, 0, 0, 1);
    chk("t1_pc", s_pc, 32'd24);
    chk("t1_instr", s_instr, 32'd6);
    chk("t1_plus4", s_plus4, 32'd28);

    // 2: back-pressure
    step(1, 0, 0, 0);
    step(0, 0, 0, 1);
    repeat (5) step(0, 0, 0, 0);
    chk("t2_addr_hold", s_addr, 32'h8);
    chk("t2_head", s_pc, 32'h0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    chk("t2_order", s_pc, 32'h8);

    // 3: redirect with a full queue
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 1, 32'h40, 0);
    chk("t3_flush_valid", 32'(s_valid), 32'h0);
    chk("t3_addr", s_addr, 32'h40);
    step(0, 0, 0, 0);
    chk("t3_pc", s_pc, 32'h40);
    chk("t3_instr", s_instr, 32'd16);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);

    // 4: misaligned redirect
    frozen = m_pc;
    step(0, 1, 32'h42, 1);
    chk("t4_fault", 32'(s_fault), 32'h1);
    chk("t4_valid", 32'(s_valid), 32'h0);
    repeat (3) step(0, 1, 32'h80, 1);
    repeat (2) step(0, 0, 0, 1);
    chk("t4_frozen", s_addr, frozen);
    chk("t4_still_fault", 32'(s_fault), 32'h1);
    step(1, 0, 0, 1);
    chk("t4_clear", 32'(s_fault), 32'h0);
    chk("t4_restart", s_addr, RPC_A);
    step(0, 0, 0, 1);
    chk("t4_resume", s_pc, RPC_A);

    // 5: PC wrap with the second instance
    hard_reset(1'b1, RPC_B);
    step(0, 0, 0, 1);
    chk("t5_pc0", s_pc, 32'hFFFF_FFF8);
    step(0, 0, 0, 1);
    chk("t5_pc1", s_pc, 32'hFFFF_FFFC);
    chk("t5_plus4_wrap", s_plus4, 32'h0);
    step(0, 0, 0, 1);
    chk("t5_pc2", s_pc, 32'h0);
    chk("t5_instr2", s_instr, 32'h0);

    // 6: reset beats full queue and redirect
    repeat (3) step(0, 0, 0, 0);
    step(1, 1, 32'h100, 0);
    chk("t6_valid", 32'(s_valid), 32'h0);
    chk("t6_addr", s_addr, RPC_B);
    chk("t6_fault", 32'(s_fault), 32'h0);
    step(0, 0, 0, 1);
    chk("t6_resume", s_pc, RPC_B);

    // Random traffic on both instances
    for (int k = 0; k < 2; k++) begin
      if (k == 1) hard_reset(1'b0, RPC_A);
      for (int i = 0; i < 300; i++) begin
        r   = ($urandom_range(0, 99) < 2);
        rv  = ($urandom_range(0, 99) < 8);
        rpc = $urandom & 32'h0000_03FF;
        if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
        rdy = ($urandom_range(0, 99) < 65);
        step(r, rv, rpc, rdy);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
